// File: rtl/lc_port_arbiter.sv
// lc_port_arbiter: round-robin share of one lower-level cache port among
// N requesters, one transaction in flight at a time.
// Ports: clk_in/rst_in (sync, active high); req_* upstream requests;
// resp_* upstream responses; lc_* downstream request/response; err_out.
module lc_port_arbiter #(
  parameter int N = 2,
  parameter int W = 64,
  parameter int L = 512
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [N-1:0]   req_valid_in,
  output logic [N-1:0]   req_ready_out,
  input  logic [N*W-1:0] req_addr_in,
  input  logic [N*L-1:0] req_value_in,
  input  logic [N-1:0]   req_we_in,
  output logic [N-1:0]   resp_valid_out,
  input  logic [N-1:0]   resp_ready_in,
  output logic [W-1:0]   resp_addr_out,
  output logic [L-1:0]   resp_value_out,
  output logic           lc_valid_out,
  input  logic           lc_ready_in,
  output logic [W-1:0]   lc_addr_out,
  output logic [L-1:0]   lc_value_out,
  output logic           we_out,
  input  logic           lc_valid_in,
  output logic           lc_ready_out,
  input  logic [W-1:0]   lc_addr_in,
  input  logic [L-1:0]   lc_value_in,
  output logic           err_out
);

  localparam int O  = $clog2(L / 8);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RET
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [PW-1:0] g_q, g_d;
  logic [W-1:0]  addr_q, addr_d;
  logic [L-1:0]  wdat_q, wdat_d;
  logic [L-1:0]  rdat_q, rdat_d;
  logic          we_q, we_d;
  logic          err_q, err_d;

  logic [PW-1:0] gnt;
  logic          gnt_vld;
  logic [W-1:0]  addr_sel;
  logic          unused_lo;

  // (a + k) mod N without a divider
  function automatic logic [PW-1:0] wrap_add(
    input logic [PW-1:0] a,
    input int            k
  );
    logic [PW:0] s;
    s = {1'b0, a} + (PW+1)'(k);
    if (s >= (PW+1)'(N)) s = s - (PW+1)'(N);
    return s[PW-1:0];
  endfunction

  // Scan from the farthest offset down so the nearest valid to rr_q wins.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_valid_in[wrap_add(rr_q, k)]) begin
        gnt     = wrap_add(rr_q, k);
        gnt_vld = 1'b1;
      end
    end
  end

  assign addr_sel  = req_addr_in[gnt*W +: W];
  assign unused_lo = ^{addr_sel[O-1:0], lc_addr_in[O-1:0]};

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    g_d            = g_q;
    addr_d         = addr_q;
    wdat_d         = wdat_q;
    rdat_d         = rdat_q;
    we_d           = we_q;
    err_d          = err_q;
    req_ready_out  = '0;
    resp_valid_out = '0;
    lc_valid_out   = 1'b0;
    lc_ready_out   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          req_ready_out[gnt] = 1'b1;
          g_d     = gnt;
          addr_d  = {addr_sel[W-1:O], {O{1'b0}}};
          wdat_d  = req_value_in[gnt*L +: L];
          we_d    = req_we_in[gnt];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        lc_valid_out = 1'b1;
        if (lc_ready_in) state_d = S_WAIT;
      end
      S_WAIT: begin
        lc_ready_out = 1'b1;
        if (lc_valid_in) begin
          if (lc_addr_in[W-1:O] == addr_q[W-1:O]) begin
            rdat_d  = lc_value_in;
            state_d = S_RET;
          end else begin
            // stray response: drop it, flag it, keep waiting
            err_d = 1'b1;
          end
        end
      end
      S_RET: begin
        resp_valid_out[g_q] = 1'b1;
        if (resp_ready_in[g_q]) begin
          rr_d    = wrap_add(g_q, 1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign lc_addr_out    = addr_q;
  assign lc_value_out   = wdat_q;
  assign we_out         = we_q;
  assign resp_addr_out  = addr_q;
  assign resp_value_out = rdat_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_lc_port_arbiter.sv
// tb_lc_port_arbiter: scoreboard bench for lc_port_arbiter.
// Expected responses are queued at request time, popped on delivery.
module tb_lc_port_arbiter;
  localparam int N = 2;
  localparam int W = 64;
  localparam int L = 512;

  typedef struct {
    int           port;
    logic [W-1:0] addr;
    logic [L-1:0] val;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid, req_ready, req_we;
  logic [N*W-1:0] req_addr;
  logic [N*L-1:0] req_value;
  logic [N-1:0]   resp_valid, resp_ready;
  logic [W-1:0]   resp_addr, lc_addr_o, lc_addr_i;
  logic [L-1:0]   resp_value, lc_value_o, lc_value_i;
  logic           lc_valid_o, lc_ready_i, we_o;
  logic           lc_valid_i, lc_ready_o, err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lc_port_arbiter #(.N(N), .W(W), .L(L)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .req_valid_in   (req_valid),
    .req_ready_out  (req_ready),
    .req_addr_in    (req_addr),
    .req_value_in   (req_value),
    .req_we_in      (req_we),
    .resp_valid_out (resp_valid),
    .resp_ready_in  (resp_ready),
    .resp_addr_out  (resp_addr),
    .resp_value_out (resp_value),
    .lc_valid_out   (lc_valid_o),
    .lc_ready_in    (lc_ready_i),
    .lc_addr_out    (lc_addr_o),
    .lc_value_out   (lc_value_o),
    .we_out         (we_o),
    .lc_valid_in    (lc_valid_i),
    .lc_ready_out   (lc_ready_o),
    .lc_addr_in     (lc_addr_i),
    .lc_value_in    (lc_value_i),
    .err_out        (err)
  );

  task automatic idle_inputs();
    req_valid = '0; req_we = '0;
    req_addr = '0; req_value = '0;
    resp_ready = '0; lc_ready_i = 1'b0;
    lc_valid_i = 1'b0; lc_addr_i = '0;
    lc_value_i = '0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic issue_req(input int p, input logic [W-1:0] a,
                           input logic we, input logic [L-1:0] v);
    req_addr[p*W +: W]  = a;
    req_value[p*L +: L] = v;
    req_we[p]    = we;
    req_valid[p] = 1'b1;
  endtask

  task automatic accept(output logic [N-1:0] rdy, output int at,
                        output bit ok);
    ok = 0; rdy = '0; at = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (|req_ready) begin
        rdy = req_ready; at = cyc; ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
  endtask

  task automatic ds_req(input int stall, output logic [W-1:0] a,
                        output logic we, output logic [L-1:0] v,
                        output bit stable, output bit ok);
    ok = 0; stable = 1; a = '0; we = 1'b0; v = '0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (lc_valid_o) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) return;
    a = lc_addr_o; we = we_o; v = lc_value_o;
    repeat (stall) begin
      @(negedge clk); #1;
      if (!lc_valid_o || lc_addr_o !== a || we_o !== we ||
          lc_value_o !== v) stable = 0;
    end
    lc_ready_i = 1'b1;
    @(negedge clk);
    lc_ready_i = 1'b0;
  endtask

  task automatic ds_resp(input logic [W-1:0] a, input logic [L-1:0] v);
    lc_valid_i = 1'b1; lc_addr_i = a; lc_value_i = v;
    @(negedge clk);
    lc_valid_i = 1'b0; lc_addr_i = '0; lc_value_i = '0;
  endtask

  task automatic collect(input int stall, output logic [N-1:0] rv,
                         output logic [W-1:0] a, output logic [L-1:0] v,
                         output int at, output bit stable, output bit ok);
    ok = 0; stable = 1; rv = '0; a = '0; v = '0; at = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (|resp_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) return;
    rv = resp_valid; a = resp_addr; v = resp_value; at = cyc;
    repeat (stall) begin
      @(negedge clk); #1;
      if (resp_valid !== rv || resp_addr !== a || resp_value !== v)
        stable = 0;
    end
    resp_ready = rv;
    @(negedge clk);
    resp_ready = '0;
  endtask

  task automatic test_reset();
    logic [N-1:0] rdy; int at; bit ok;
    idle_inputs();
    do_reset(2);
    #1;
    checks++;
    if ({req_ready, resp_valid, lc_valid_o, lc_ready_o, we_o, err,
         lc_addr_o, resp_addr} !== '0 || lc_value_o !== '0 ||
        resp_value !== '0) begin
      errors++;
      $display("FAIL reset_out rdy=%b rv=%b lcv=%b lcr=%b we=%b err=%b required all 0",
               req_ready, resp_valid, lc_valid_o, lc_ready_o, we_o, err);
    end
    issue_req(0, 64'h100, 1'b0, '0);
    issue_req(1, 64'h200, 1'b0, '0);
    accept(rdy, at, ok);
    checks++;
    if (!ok || rdy !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_grant got %b required 01", rdy);
    end
    idle_inputs();
    do_reset(1);
  endtask

  task automatic test_single_read();
    logic [N-1:0] rdy, rv; logic [W-1:0] a, ra; logic [L-1:0] v, rd;
    logic we; int t0, t1; bit ok, st; exp_t e;
    issue_req(0, 64'h4000, 1'b0, '0);
    sb.push_back('{0, 64'h4000, L'(64'h0123456789ABCDEF)});
    accept(rdy, t0, ok);
    req_valid[0] = 1'b0;
    checks++;
    if (!ok || rdy !== 2'b01) begin
      errors++;
      $display("FAIL sr_grant got %b required 01", rdy);
    end
    ds_req(0, a, we, v, st, ok);
    checks++;
    if (!ok || a !== 64'h4000 || we !== 1'b0) begin
      errors++;
      $display("FAIL sr_lc_req got addr=%h we=%b required addr=4000 we=0", a, we);
    end
    ds_resp(64'h4000, L'(64'h0123456789ABCDEF));
    collect(0, rv, ra, rd, t1, st, ok);
    e = sb.pop_front();
    checks++;
    if (rv !== (N'(1) << e.port) || ra !== e.addr || rd !== e.val) begin
      errors++;
      $display("FAIL sr_resp got rv=%b addr=%h data=%h required rv=%b addr=%h data=%h",
               rv, ra, rd[63:0], N'(1) << e.port, e.addr, e.val[63:0]);
    end
    checks++;
    if (t1 - t0 != 3) begin
      errors++;
      $display("FAIL sr_latency got %0d required 3", t1 - t0);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] rdy, rv; logic [W-1:0] a, ra; logic [L-1:0] v, rd;
    logic we; int t; bit ok, st; exp_t e;
    int order [6] = '{0, 1, 0, 1, 1, 0};
    do_reset(1);
    issue_req(0, 64'h1000, 1'b0, '0);
    issue_req(1, 64'h2040, 1'b0, '0);
    for (int k = 0; k < 6; k++) begin
      if (k == 4) req_valid[0] = 1'b0;
      if (k == 5) req_valid[0] = 1'b1;
      e.port = order[k];
      e.addr = (order[k] == 1) ? 64'h2040 : 64'h1000;
      e.val  = L'({32'(k + 1), e.addr});
      sb.push_back(e);
      accept(rdy, t, ok);
      checks++;
      if (!ok || rdy !== (N'(1) << order[k])) begin
        errors++;
        $display("FAIL rr_grant_%0d got %b required %b", k, rdy,
                 N'(1) << order[k]);
      end
      ds_req(0, a, we, v, st, ok);
      ds_resp(a, L'({32'(k + 1), a}));
      if (k == 5) req_valid = '0;
      collect(0, rv, ra, rd, t, st, ok);
      e = sb.pop_front();
      checks++;
      if (rv !== (N'(1) << e.port) || ra !== e.addr || rd !== e.val) begin
        errors++;
        $display("FAIL rr_resp_%0d got rv=%b addr=%h required rv=%b addr=%h",
                 k, rv, ra, N'(1) << e.port, e.addr);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_writeback();
    logic [N-1:0] rdy, rv; logic [W-1:0] a, ra; logic [L-1:0] v, rd;
    logic we; int t; bit ok, st; exp_t e;
    issue_req(1, 64'h54, 1'b1, L'(32'hDEADBEEF));
    sb.push_back('{1, 64'h40, L'(16'h0ACE)});
    accept(rdy, t, ok);
    req_valid[1] = 1'b0;
    checks++;
    if (!ok || rdy !== 2'b10) begin
      errors++;
      $display("FAIL wb_grant got %b required 10", rdy);
    end
    ds_req(0, a, we, v, st, ok);
    checks++;
    if (!ok || a !== 64'h40 || we !== 1'b1 || v !== L'(32'hDEADBEEF)) begin
      errors++;
      $display("FAIL wb_lc_req got addr=%h we=%b data=%h required addr=40 we=1 data=deadbeef",
               a, we, v[63:0]);
    end
    ds_resp(64'h40, L'(16'h0ACE));
    collect(0, rv, ra, rd, t, st, ok);
    e = sb.pop_front();
    checks++;
    if (rv !== (N'(1) << e.port) || ra !== e.addr || rd !== e.val) begin
      errors++;
      $display("FAIL wb_resp got rv=%b addr=%h data=%h required rv=%b addr=%h data=%h",
               rv, ra, rd[63:0], N'(1) << e.port, e.addr, e.val[63:0]);
    end
  endtask

  task automatic test_mismatch();
    logic [N-1:0] rdy, rv; logic [W-1:0] a, ra; logic [L-1:0] v, rd;
    logic we; int t; bit ok, st; exp_t e;
    issue_req(0, 64'h4000, 1'b0, '0);
    sb.push_back('{0, 64'h4000, L'(64'h0CAD456789AACDEF)});
    accept(rdy, t, ok);
    req_valid[0] = 1'b0;
    ds_req(0, a, we, v, st, ok);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL mm_err_before got %b required 0", err);
    end
    ds_resp(64'h34000, '1);
    #1;
    checks++;
    if (err !== 1'b1 || lc_ready_o !== 1'b1 || resp_valid !== '0) begin
      errors++;
      $display("FAIL mm_discard got err=%b lcr=%b rv=%b required err=1 lcr=1 rv=00",
               err, lc_ready_o, resp_valid);
    end
    ds_resp(64'h4000, L'(64'h0CAD456789AACDEF));
    collect(0, rv, ra, rd, t, st, ok);
    e = sb.pop_front();
    checks++;
    if (rv !== (N'(1) << e.port) || ra !== e.addr || rd !== e.val) begin
      errors++;
      $display("FAIL mm_resp got rv=%b addr=%h data=%h required rv=%b addr=%h data=%h",
               rv, ra, rd[63:0], N'(1) << e.port, e.addr, e.val[63:0]);
    end
  endtask

  task automatic test_backpressure_reset();
    logic [N-1:0] rdy, rv; logic [W-1:0] a, ra; logic [L-1:0] v, rd;
    logic we; int t; bit ok, st; exp_t e;
    issue_req(1, 64'h8000, 1'b0, '0);
    sb.push_back('{1, 64'h8000, L'(64'h5555)});
    accept(rdy, t, ok);
    req_valid[1] = 1'b0;
    ds_req(3, a, we, v, st, ok);
    checks++;
    if (!ok || !st || a !== 64'h8000) begin
      errors++;
      $display("FAIL bp_lc_stable got ok=%b stable=%b addr=%h required 1 1 8000",
               ok, st, a);
    end
    ds_resp(64'h8000, L'(64'h5555));
    collect(3, rv, ra, rd, t, st, ok);
    checks++;
    if (!st) begin
      errors++;
      $display("FAIL bp_resp_stable got %b required 1", st);
    end
    e = sb.pop_front();
    checks++;
    if (rv !== (N'(1) << e.port) || ra !== e.addr || rd !== e.val) begin
      errors++;
      $display("FAIL bp_resp got rv=%b addr=%h required rv=%b addr=%h",
               rv, ra, N'(1) << e.port, e.addr);
    end
    issue_req(0, 64'hC000, 1'b0, '0);
    accept(rdy, t, ok);
    req_valid[0] = 1'b0;
    ds_req(0, a, we, v, st, ok);
    do_reset(1);
    #1;
    checks++;
    if ({req_ready, resp_valid, lc_valid_o, lc_ready_o, we_o, err,
         lc_addr_o, resp_addr} !== '0 || resp_value !== '0) begin
      errors++;
      $display("FAIL wait_reset got rv=%b lcv=%b lcr=%b err=%b addr=%h required all 0",
               resp_valid, lc_valid_o, lc_ready_o, err, lc_addr_o);
    end
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_round_robin();
    test_writeback();
    test_mismatch();
    test_backpressure_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
